// File: rtl/muldiv_seq_if.sv
// Issue/complete interface for the sequential multiply/divide unit.
// Handshake: start is honoured only while busy=0 (no queuing); the unit then raises done
// for exactly one cycle with result/div_zero valid, and both hold until the next accepted start.
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rn;
  logic [31:0] rm;
  logic [31:0] ra;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        div_zero;
  logic [1:0]  dbg_state;

  modport mst (
    output start, op, rn, rm, ra,
    input  busy, stall, done, result, div_zero, dbg_state
  );

  modport slv (
    input  start, op, rn, rm, ra,
    output busy, stall, done, result, div_zero, dbg_state
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MUL/MLA/UDIV/SDIV: one radix-2 step per cycle, 32 steps per operation.
// Shift-add multiply and restoring divide share the same three working registers.
module muldiv_seq (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slv    bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MLA  = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  state_t      r_state;
  state_t      w_next;
  logic        w_stall;
  logic        w_zero_div;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_acc;
  logic [31:0] r_ra;
  logic        r_neg;
  logic        r_dz_pend;
  logic        r_hold;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_div_zero;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic [31:0] w_abs_rn;
  logic [31:0] w_abs_rm;

  assign w_zero_div = bus.op[1] && (bus.rm == 32'd0);
  assign w_abs_rn   = bus.rn[31] ? (32'd0 - bus.rn) : bus.rn;
  assign w_abs_rm   = bus.rm[31] ? (32'd0 - bus.rm) : bus.rm;

  // Restoring divide step: partial remainder in r_acc, dividend bits shift out of r_x
  // while quotient bits shift in behind them.
  assign w_shift = {r_acc, r_x[31]};
  assign w_trial = w_shift - {1'b0, r_y};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_stall = 1'b1;
          w_next  = w_zero_div ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        w_stall = 1'b1;
        if (r_cnt == 5'd31) w_next = S_FIN;
      end
      S_FIN: begin
        w_stall = 1'b1;
        if (!r_hold) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= 5'd0;
      r_op       <= OP_MUL;
      r_x        <= 32'd0;
      r_y        <= 32'd0;
      r_acc      <= 32'd0;
      r_ra       <= 32'd0;
      r_neg      <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= 32'd0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op       <= bus.op;
            r_ra       <= bus.ra;
            r_cnt      <= 5'd0;
            r_acc      <= 32'd0;
            r_div_zero <= 1'b0;
            r_dz_pend  <= w_zero_div;
            // Divide-by-zero spends two cycles in FIN so done lands two edges after accept.
            r_hold     <= w_zero_div;
            if (bus.op == OP_SDIV) begin
              r_x   <= w_abs_rn;
              r_y   <= w_abs_rm;
              r_neg <= bus.rn[31] ^ bus.rm[31];
            end else begin
              r_x   <= bus.rn;
              r_y   <= bus.rm;
              r_neg <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_op[1]) begin
            if (!w_trial[32]) begin
              r_acc <= w_trial[31:0];
              r_x   <= {r_x[30:0], 1'b1};
            end else begin
              r_acc <= w_shift[31:0];
              r_x   <= {r_x[30:0], 1'b0};
            end
          end else begin
            if (r_y[0]) r_acc <= r_acc + r_x;
            r_x <= {r_x[30:0], 1'b0};
            r_y <= {1'b0, r_y[31:1]};
          end
        end
        S_FIN: begin
          if (r_hold) begin
            r_hold <= 1'b0;
          end else begin
            r_done     <= 1'b1;
            r_div_zero <= r_dz_pend;
            if (r_dz_pend) begin
              r_result <= 32'd0;
            end else begin
              case (r_op)
                OP_MUL:  r_result <= r_acc;
                OP_MLA:  r_result <= r_acc + r_ra;
                OP_UDIV: r_result <= r_x;
                default: r_result <= r_neg ? (32'd0 - r_x) : r_x;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.stall     = w_stall;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.div_zero  = r_div_zero;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic/latency model checked every cycle plus directed literal cases.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_seq_if bus();
  muldiv_seq dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the operation definitions.
  function automatic logic [31:0] f_calc(input logic [1:0] op, input logic [31:0] rn,
                                         input logic [31:0] rm, input logic [31:0] ra);
    longint a, b, q;
    logic [63:0] q64;
    case (op)
      2'b00: f_calc = rn * rm;
      2'b01: f_calc = rn * rm + ra;
      2'b10: f_calc = (rm == 0) ? 32'd0 : rn / rm;
      default: begin
        if (rm == 0) f_calc = 32'd0;
        else begin
          a = longint'($signed(rn));
          b = longint'($signed(rm));
          q = a / b;
          q64 = q;
          f_calc = q64[31:0];
        end
      end
    endcase
  endfunction

  // Cycle model: edge count, accept/done timing from the latency rules, scoreboard of results.
  int          cyc = 0;
  bit          m_busy, m_done, m_dz, m_pend_dz;
  int          m_done_at;
  logic [31:0] m_result;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_result = 32'd0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_busy && cyc == m_done_at) begin
        m_done   = 1;
        m_result = exp_q.pop_front();
        m_dz     = m_pend_dz;
      end else if (m_busy && cyc == m_done_at + 1) begin
        m_done = 0;
        m_busy = 0;
      end else if (!m_busy && bus.start) begin
        m_busy    = 1;
        m_dz      = 0;
        m_pend_dz = bus.op[1] && (bus.rm == 32'd0);
        exp_q.push_back(f_calc(bus.op, bus.rn, bus.rm, bus.ra));
        m_done_at = cyc + (m_pend_dz ? 2 : 33);
        acc_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",     {31'd0, bus.busy},     {31'd0, m_busy});
    chk("done",     {31'd0, bus.done},     {31'd0, m_done});
    chk("stall",    {31'd0, bus.stall},
        {31'd0, (!m_busy && bus.start) || (m_busy && cyc < m_done_at)});
    chk("div_zero", {31'd0, bus.div_zero}, {31'd0, m_dz});
    chk("result",   bus.result,            m_result);
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [31:0] ra, output int k, output int d);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.rn = rn; bus.rm = rm; bus.ra = ra;
    k = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 2'($urandom_range(0, 3));
    bus.rn = $urandom; bus.rm = $urandom; bus.ra = $urandom;
    d = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        d = cyc;
        break;
      end
    end
  endtask

  task automatic run_case(input string name, input logic [1:0] op, input logic [31:0] rn,
                          input logic [31:0] rm, input logic [31:0] ra,
                          input logic [31:0] exp_res, input bit exp_dz, input int exp_lat);
    int k, d;
    do_op(op, rn, rm, ra, k, d);
    chk({name, "_latency"}, d - k, exp_lat);
    chk({name, "_result"},  bus.result, exp_res);
    chk({name, "_divzero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int k, d, n_done;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rn = 32'd0; bus.rm = 32'd0; bus.ra = 32'd0;
    #1;
    chk("rst_busy",   {31'd0, bus.busy},     32'd0);
    chk("rst_done",   {31'd0, bus.done},     32'd0);
    chk("rst_stall",  {31'd0, bus.stall},    32'd0);
    chk("rst_result", bus.result,            32'd0);
    chk("rst_dz",     {31'd0, bus.div_zero}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_case("mul_7x6",     2'b00, 32'd7,        32'd6,        32'd0, 32'd42,       1'b0, 33);
    run_case("mla_wrap",    2'b01, 32'hFFFFFFFF, 32'd2,        32'd5, 32'h00000003, 1'b0, 33);
    run_case("udiv_100_7",  2'b10, 32'd100,      32'd7,        32'd0, 32'd14,       1'b0, 33);
    run_case("sdiv_m100_7", 2'b11, 32'hFFFFFF9C, 32'd7,        32'd0, 32'hFFFFFFF2, 1'b0, 33);
    run_case("sdiv_ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33);
    run_case("sdiv_7_m2",   2'b11, 32'd7,        32'hFFFFFFFE, 32'd0, 32'hFFFFFFFD, 1'b0, 33);
    run_case("udiv_big",    2'b10, 32'hFFFFFFFF, 32'd16,       32'd0, 32'h0FFFFFFF, 1'b0, 33);
    run_case("udiv_by0",    2'b10, 32'd5,        32'd0,        32'd0, 32'd0,        1'b1, 2);
    run_case("mul_neg",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1,        1'b0, 33);
    run_case("sdiv_by0",    2'b11, 32'h80000000, 32'd0,        32'd0, 32'd0,        1'b1, 2);
    run_case("mla_small",   2'b01, 32'd1000,     32'd1000,     32'd7, 32'd1000007,  1'b0, 33);

    // start held high: only one accept per completed operation
    acc_q.delete();
    n_done = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.rn = 32'd3; bus.rm = 32'd5; bus.ra = 32'd0;
    k = cyc + 1;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      if (i == 70) bus.start = 1'b0;
      if (bus.done) n_done++;
    end
    chk("held_done_count", n_done, 32'd3);
    chk("held_accepts",    acc_q.size(), 32'd3);
    if (acc_q.size() == 3) begin
      chk("held_acc0", acc_q[0] - k, 32'd0);
      chk("held_acc1", acc_q[1] - k, 32'd35);
      chk("held_acc2", acc_q[2] - k, 32'd70);
    end
    chk("held_result", bus.result, 32'd15);

    // reset in the middle of a divide
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b10; bus.rn = 32'd1000; bus.rm = 32'd3;
    k = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 20 && cyc < k + 10; i++) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy",   {31'd0, bus.busy},     32'd0);
    chk("abort_done",   {31'd0, bus.done},     32'd0);
    chk("abort_result", bus.result,            32'd0);
    chk("abort_dz",     {31'd0, bus.div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("abort_no_done", n_done, 32'd0);
    run_case("after_reset", 2'b10, 32'd1000, 32'd3, 32'd0, 32'd333, 1'b0, 33);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: none; all widths fixed at 32-bit operands and result.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  request a new operation; accepted only in IDLE.
REQ-005 op  input  2  00 MUL, 01 MLA, 10 UDIV, 11 SDIV.
REQ-006 rn  input  32  first operand (multiplicand / dividend).
REQ-007 rm  input  32  second operand (multiplier / divisor).
REQ-008 ra  input  32  accumulate operand; used by MLA only.
REQ-009 busy  output  1  1 whenever state != IDLE.
REQ-010 stall  output  1  PC/register-write hold for the datapath; 1 on the accept cycle and in RUN and FIN, else 0.
REQ-011 done  output  1  one-cycle pulse; result valid; the datapath uses it as the register write enable.
REQ-012 result  output  32  registered result; held from done until the next accepted start.
REQ-013 div_zero  output  1  registered; 1 when the last completed divide had rm = 0.

Function
REQ-014 FSM states: IDLE, RUN, FIN, DONE.
REQ-015 IDLE -> RUN on start=1: latch op, rn, rm, ra; clear 5-bit iteration counter; clear div_zero.
REQ-016 Exception: IDLE -> FIN directly when op is UDIV or SDIV and rm = 0.
REQ-017 RUN executes one radix-2 step per cycle (shift-add multiply or restoring divide) and increments the counter.
REQ-018 RUN -> FIN after exactly 32 RUN cycles, on the edge where the counter = 31.
REQ-019 FIN registers result (accumulate add for MLA; sign fix for SDIV), then -> DONE.
REQ-020 DONE asserts done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-021 Latency: with start sampled at edge k, done rises at edge k+33 and falls at edge k+34.
REQ-022 Latency for divide-by-zero: done rises at edge k+2.
REQ-023 start=1 in RUN, FIN or DONE is ignored (no queuing); a new start is accepted no earlier than the IDLE cycle after DONE.
REQ-024 Operand inputs are don't-care after the accept edge; latched copies only are used.
REQ-025 MUL: result = low 32 bits of rn*rm (unsigned and signed give an identical low word).
REQ-026 MLA: result = (rn*rm + ra) mod 2^32.
REQ-027 UDIV: result = floor(rn/rm), unsigned.
REQ-028 SDIV: divide |rn| by |rm| unsigned; negate the quotient if the signs differ; truncate toward zero.
REQ-029 SDIV 0x80000000 / 0xFFFFFFFF: result = 0x80000000 (two's-complement wrap, no flag).
REQ-030 Divide by zero (rm=0, UDIV or SDIV): result = 0, div_zero=1, no RUN cycles.
REQ-031 stall is combinational: (state==IDLE & start) | state==RUN | state==FIN.
REQ-032 done, busy, result, div_zero are registered outputs, free of combinational paths from inputs.

Reset
REQ-033 reset=0 forces asynchronously: state=IDLE, counter=0, busy=0, done=0, result=0, div_zero=0; stall then follows REQ-031 (0 while start=0).
REQ-034 Reset asserted mid-operation aborts the operation; no done pulse is produced for it.
REQ-035 After reset deasserts, the first rising edge with start=1 is accepted.

Verification
REQ-036 MUL rn=7, rm=6, start at edge k -> done=1 at edge k+33 only, result=42, stall=1 from the accept cycle through FIN.
REQ-037 MLA rn=0xFFFFFFFF, rm=2, ra=5 -> result=0x00000003; UDIV 100/7 -> result=14, div_zero=0.
REQ-038 SDIV rn=0xFFFFFF9C (-100), rm=7 -> result=0xFFFFFFF2 (-14); SDIV 0x80000000/0xFFFFFFFF -> result=0x80000000.
REQ-039 UDIV rn=5, rm=0 -> done at edge k+2, result=0, div_zero=1; next MUL clears div_zero on accept.
REQ-040 start held high continuously -> operations accepted only at edges k, k+35, k+70; each gives one done pulse.
REQ-041 reset pulsed low at edge k+10 of a divide -> all outputs 0 immediately; no done; a new start after release completes normally.
